// File: rtl/cb_mod.sv
`default_nettype none
// ============================================================================
//  Module      : cb_mod
//  Description : Parametrised synchronous up/down modulus counter with
//                parallel load, synchronous set/clear, cascade carry-in/out
//                and a sticky overflow flag. Wrap or saturate at terminal.
//  Revision    : 1.0 - initial release
// ============================================================================
module cb_mod #(
    parameter int     WIDTH    = 8,
    parameter longint MODULUS  = 256,
    parameter bit     SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             sset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ena,
    input  logic             cin,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt_qout,
    output logic             tc,
    output logic             cout,
    output logic             ovf
);

    // Comparisons are done one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   C_MOD_X = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   C_MAX_X = C_MOD_X - {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MAX   = C_MAX_X[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   w_q_x;
    logic [WIDTH:0]   w_din_x;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_din_ok;

    assign w_q_x     = {1'b0, cnt_q};
    assign w_din_x   = {1'b0, din};
    assign w_at_max  = (w_q_x == C_MAX_X);
    assign w_at_zero = (cnt_q == '0);
    assign w_din_ok  = (w_din_x < C_MOD_X);

    // Next-state selection: set, load, count, hold (clear is applied in the register).
    // Increment/decrement cannot overflow WIDTH bits because they are only
    // taken strictly inside the 0..MODULUS-1 range.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (sset) begin
            cnt_d = C_MAX;
        end else if (load) begin
            if (w_din_ok) begin
                cnt_d = din;
                ovf_d = 1'b0;
            end else begin
                cnt_d = C_MAX;
                ovf_d = 1'b1;
            end
        end else if (ena && cin) begin
            if (dir) begin
                if (w_at_max) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + C_ONE;
                end
            end else begin
                if (w_at_zero) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) cnt_d = C_MAX;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
        end
    end

    // State register; clear overrides every other control.
    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Terminal count follows direction combinationally so cascades ripple in one cycle.
    assign tc       = cin & (dir ? w_at_max : w_at_zero);
    assign cout     = tc & ena;
    assign cnt_qout = cnt_q;
    assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cb_mod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cb_mod
//  Description : Directed-vector scoreboard bench for cb_mod (WIDTH=4,
//                MODULUS=10): wrap unit, saturate unit and a two-digit cascade.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cb_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // unit 0 : wrapping counter
    logic       u0_sclr = 0, u0_sset = 0, u0_load = 0, u0_ena = 0, u0_cin = 1, u0_dir = 0;
    logic [3:0] u0_din = 0;
    logic [3:0] u0_q;
    logic       u0_tc, u0_cout, u0_ovf;

    // unit 1 : saturating counter
    logic       u1_sclr = 0, u1_sset = 0, u1_load = 0, u1_ena = 0, u1_cin = 1, u1_dir = 0;
    logic [3:0] u1_din = 0;
    logic [3:0] u1_q;
    logic       u1_tc, u1_cout, u1_ovf;

    // unit 2 : two-stage cascade
    logic       c_sclr = 0, c_sset = 0, c_load = 0, c_ena = 0, c_dir = 0;
    logic [3:0] c_din = 0;
    logic [3:0] c0_q, c1_q;
    logic       c0_tc, c0_cout, c0_ovf, c1_tc, c1_cout, c1_ovf;

    cb_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .sclr(u0_sclr), .sset(u0_sset), .load(u0_load), .din(u0_din),
        .ena(u0_ena), .cin(u0_cin), .dir(u0_dir),
        .cnt_qout(u0_q), .tc(u0_tc), .cout(u0_cout), .ovf(u0_ovf));

    cb_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .sclr(u1_sclr), .sset(u1_sset), .load(u1_load), .din(u1_din),
        .ena(u1_ena), .cin(u1_cin), .dir(u1_dir),
        .cnt_qout(u1_q), .tc(u1_tc), .cout(u1_cout), .ovf(u1_ovf));

    cb_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .sclr(c_sclr), .sset(c_sset), .load(c_load), .din(c_din),
        .ena(c_ena), .cin(1'b1), .dir(c_dir),
        .cnt_qout(c0_q), .tc(c0_tc), .cout(c0_cout), .ovf(c0_ovf));

    cb_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .sclr(c_sclr), .sset(c_sset), .load(c_load), .din(c_din),
        .ena(c_ena), .cin(c0_cout), .dir(c_dir),
        .cnt_qout(c1_q), .tc(c1_tc), .cout(c1_cout), .ovf(c1_ovf));

    // Expected observation at the negedge of the cycle the controls are driven.
    // mask bits: [3]=q [2]=ovf [1]=tc [0]=cout
    typedef struct {
        int         u;
        logic [3:0] m;
        logic [7:0] q;
        logic       ov;
        logic       t;
        logic       co;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Drive one cycle of controls for a unit and queue its expected observation.
    task automatic vec(input int u, input logic s_clr, input logic s_set, input logic ld,
                       input logic [3:0] d, input logic en, input logic ci, input logic dr,
                       input logic [3:0] m, input logic [7:0] q, input logic ov,
                       input logic t, input logic co, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        case (u)
            0: begin
                u0_sclr = s_clr; u0_sset = s_set; u0_load = ld; u0_din = d;
                u0_ena = en; u0_cin = ci; u0_dir = dr;
            end
            1: begin
                u1_sclr = s_clr; u1_sset = s_set; u1_load = ld; u1_din = d;
                u1_ena = en; u1_cin = ci; u1_dir = dr;
            end
            default: begin
                c_sclr = s_clr; c_sset = s_set; c_load = ld; c_din = d;
                c_ena = en; c_dir = dr;
            end
        endcase
        e.u = u; e.m = m; e.q = q; e.ov = ov; e.t = t; e.co = co; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per negedge and compares the selected unit.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] aq;
            logic       aov, at, aco;
            e = sb.pop_front();
            case (e.u)
                0:       begin aq = {4'd0, u0_q}; aov = u0_ovf; at = u0_tc; aco = u0_cout; end
                1:       begin aq = {4'd0, u1_q}; aov = u1_ovf; at = u1_tc; aco = u1_cout; end
                default: begin aq = {c1_q, c0_q}; aov = c1_ovf; at = c1_tc; aco = c0_cout; end
            endcase
            if (e.m[3]) begin
                total++;
                if (aq !== e.q) begin
                    bad++;
                    $display("FAIL %s q: got %0h want %0h", e.nm, aq, e.q);
                end
            end
            if (e.m[2]) begin
                total++;
                if (aov !== e.ov) begin
                    bad++;
                    $display("FAIL %s ovf: got %b want %b", e.nm, aov, e.ov);
                end
            end
            if (e.m[1]) begin
                total++;
                if (at !== e.t) begin
                    bad++;
                    $display("FAIL %s tc: got %b want %b", e.nm, at, e.t);
                end
            end
            if (e.m[0]) begin
                total++;
                if (aco !== e.co) begin
                    bad++;
                    $display("FAIL %s cout: got %b want %b", e.nm, aco, e.co);
                end
            end
        end
    end

    initial begin
        // ---- 1: reset and up-count wrap (wrap unit) ----
        //   u s  s  l  din en ci dr mask   q   ov tc co
        vec(0, 1, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, "rst_pulse");
        vec(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 1, 0, "rst_state");
        for (int k = 0; k < 12; k++)
            vec(0, 0, 0, 0, 0, 1, 1, 1, 4'hF, 8'(k % 10), (k >= 10), (k == 9), (k == 9), "up_wrap");
        vec(0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 2, 1, 0, 0, "up_end");

        // ---- 2: down wrap and clamped load ----
        vec(0, 0, 0, 1, 3,  0, 1, 0, 4'hF, 2, 1, 0, 0, "ld3");
        vec(0, 0, 0, 0, 0,  1, 1, 0, 4'hF, 3, 0, 0, 0, "dn3");
        vec(0, 0, 0, 0, 0,  1, 1, 0, 4'hF, 2, 0, 0, 0, "dn2");
        vec(0, 0, 0, 0, 0,  1, 1, 0, 4'hF, 1, 0, 0, 0, "dn1");
        vec(0, 0, 0, 0, 0,  1, 1, 0, 4'hF, 0, 0, 1, 1, "dn0");
        vec(0, 0, 0, 1, 12, 0, 1, 0, 4'hF, 9, 1, 0, 0, "dn_wrap9");
        vec(0, 0, 0, 1, 5,  0, 1, 0, 4'hF, 9, 1, 0, 0, "ld12_clamp");
        vec(0, 0, 0, 1, 12, 0, 1, 0, 4'hF, 5, 0, 0, 0, "ld5");
        vec(0, 0, 0, 1, 9,  0, 1, 1, 4'hF, 9, 1, 1, 0, "ld12_again");
        vec(0, 0, 0, 0, 0,  0, 1, 1, 4'hF, 9, 0, 1, 0, "ld9_term");

        // ---- 4: priority ----
        vec(0, 1, 1, 1, 4, 1, 1, 1, 4'hF, 9, 0, 1, 1, "pri_all");
        vec(0, 0, 1, 1, 4, 0, 1, 1, 4'hF, 0, 0, 0, 0, "pri_sclr");
        vec(0, 0, 0, 1, 4, 1, 1, 1, 4'hF, 9, 0, 1, 1, "pri_sset");
        vec(0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 4, 0, 0, 0, "pri_load");

        // ---- 6: cin gating and mid-run clear ----
        vec(0, 0, 0, 1, 7, 0, 1, 1, 4'hF, 4, 0, 0, 0, "g_ld7");
        vec(0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 7, 0, 0, 0, "g_hold1");
        vec(0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 7, 0, 0, 0, "g_hold2");
        vec(0, 1, 0, 0, 0, 1, 0, 1, 4'hF, 7, 0, 0, 0, "g_hold3_clr");
        vec(0, 0, 0, 0, 0, 1, 0, 1, 4'hF, 0, 0, 0, 0, "g_after_clr");
        vec(0, 0, 0, 0, 0, 1, 0, 0, 4'hF, 0, 0, 0, 0, "g_cin0_dn");

        // ---- 3: saturate unit ----
        vec(1, 1, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, "s_rst");
        vec(1, 0, 0, 1, 8, 0, 1, 1, 4'hF, 0, 0, 0, 0, "s_ld8");
        vec(1, 0, 0, 0, 0, 1, 1, 1, 4'hF, 8, 0, 0, 0, "s_up8");
        vec(1, 0, 0, 0, 0, 1, 1, 1, 4'hF, 9, 0, 1, 1, "s_up9");
        vec(1, 0, 0, 0, 0, 1, 1, 1, 4'hF, 9, 1, 1, 1, "s_hold9");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 4'hF, 9, 1, 0, 0, "s_dn9");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 4'hF, 8, 1, 0, 0, "s_dn8");
        vec(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 7, 1, 0, 0, "s_at7");
        vec(1, 0, 0, 1, 1, 0, 1, 0, 4'hF, 7, 1, 0, 0, "s_ld1");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 4'hF, 1, 0, 0, 0, "s_dn1");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 4'hF, 0, 0, 1, 1, "s_dn0");
        vec(1, 0, 0, 0, 0, 1, 1, 0, 4'hF, 0, 1, 1, 1, "s_hold0");
        vec(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 1, 1, 0, "s_idle0");

        // ---- 5: two-digit cascade counting 00..25 ----
        vec(2, 1, 0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, "c_rst");
        for (int i = 0; i <= 25; i++)
            vec(2, 0, 0, 0, 0, (i < 25), 1, 1, 4'h9,
                {4'(i / 10), 4'(i % 10)}, 0, 0, ((i % 10) == 9), "casc");

        // let the monitor drain, bounded
        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cb_mod.md
# cb_mod

Parametrised synchronous up/down counter with modulus, load, synchronous set/clear, cascade carry-in/out and a sticky overflow flag. It is the next generation of the 4-bit `cb` counter: arbitrary width, a non-power-of-two modulus (BCD decades, timers, dividers), and selectable wrap or saturate behaviour. Multiple instances chain through `cin`/`cout` to form multi-digit counters.

## Interface
- `WIDTH`, default 8: counter width in bits, 2..32.
- `MODULUS`, default 256: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH.
- `SATURATE`, default 0: selects the terminal behaviour.
  - 0: wrap at the terminal value.
  - 1: hold at the terminal value.

Ports:
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `sclr`, input, 1: synchronous, active-high reset/clear. Highest priority.
- `sset`, input, 1: synchronous set of the count to MODULUS-1.
- `load`, input, 1: synchronous parallel load from `din`.
- `din`, input, WIDTH: load value.
- `ena`, input, 1: count enable.
- `cin`, input, 1: cascade enable. Tie to 1 on the least-significant stage.
- `dir`, input, 1: count direction. 1 counts up, 0 counts down.
- `cnt_qout`, output, WIDTH: registered count.
- `tc`, output, 1: combinational terminal-count flag.
- `cout`, output, 1: combinational cascade carry/borrow out.
- `ovf`, output, 1: registered sticky overflow flag.

## Operation
Priority per rising edge, with the first matching case applied:
1. `sclr` = 1: `cnt_qout` ← 0 and `ovf` ← 0.
2. `sset` = 1: `cnt_qout` ← MODULUS-1. `ovf` is unchanged.
3. `load` = 1:
   - If `din` < MODULUS: `cnt_qout` ← `din` and `ovf` ← 0.
   - Otherwise: `cnt_qout` ← MODULUS-1 and `ovf` ← 1 (out-of-range load is clamped).
4. `ena` & `cin` = 1, counting up (`dir` = 1):
   - If q < MODULUS-1: q ← q+1.
   - If q = MODULUS-1: q ← 0 when SATURATE=0, q holds when SATURATE=1. In both cases `ovf` ← 1.
5. `ena` & `cin` = 1, counting down (`dir` = 0):
   - If q > 0: q ← q-1.
   - If q = 0: q ← MODULUS-1 when SATURATE=0, q holds when SATURATE=1. In both cases `ovf` ← 1.
6. Otherwise: hold.

Flag and arithmetic rules:
- `tc` = `cin` & (`dir` ? q == MODULUS-1 : q == 0).
- `cout` = `tc` & `ena`. It is asserted in exactly the cycle in which this stage wraps or saturates, and enables the next stage on the same edge.
- `ena`, `cin` and `dir` are ignored whenever `sclr`, `sset` or `load` is active.
- All internal arithmetic uses WIDTH+1 bits so that MODULUS = 2**WIDTH compares correctly.
- q never leaves 0..MODULUS-1.
- A `dir` change takes effect on the same edge it is sampled. `tc` and `cout` follow `dir` combinationally.

## Timing
- Latency: one clock from sampled control to the new `cnt_qout`/`ovf` value.
- `tc` and `cout` are purely combinational from q, `dir`, `cin` and `ena`. They carry no register delay, so a cascade of N stages forms a combinational ripple chain.
- Reset values after an edge with `sclr` = 1:
  - `cnt_qout` = 0.
  - `ovf` = 0.
  - `tc` = `cin` & ~`dir`.
  - `cout` = `tc` & `ena`.
- Power-up before the first `sclr` is undefined. The bench applies `sclr` for at least one edge.
- Reset mid-count: `sclr` overrides a simultaneous `load`, `sset` or terminal-count event. The next cycle shows 0 with `ovf` cleared.
- `sset` with `load` in the same cycle: `sset` wins.
- A `load` of a value at the terminal point asserts `tc` in the following cycle without setting `ovf`.
- The bench drives inputs after `posedge` and checks outputs at `negedge`.

## Test plan
All scenarios use WIDTH=4, MODULUS=10.
1. Reset: `sclr` pulse, then `ena`=1, `dir`=1 for 12 cycles → 1,2,…,9,0,1,2. `cout`=1 only while q=9. `ovf`=1 from the wrap edge onward.
2. Down wrap and clamped load: load 3, then 4 down-counts → 2,1,0,9 with `tc` high at q=0. Then load `din`=12 → q=9, `ovf`=1. Then load 5 → q=5, `ovf`=0.
3. Saturate: SATURATE=1, load 8, then up ×3 → 9,9,9 with `ovf`=1 and `tc` held high. Then `dir`=0, down ×2 → 8,7.
4. Priority: assert `sclr`, `sset`, `load` (`din`=4) and `ena` together → q=0. Next cycle `sset`+`load` → q=9. Next cycle `load` with `ena` → q=4.
5. Cascade: two stages, stage0 `cin`=1 and stage1 `cin`=stage0 `cout`. Count up from 00 for 25 cycles → digits read 25. Stage1 steps exactly at stage0's 9→0 edges.
6. Gating: `ena`=1 with `cin`=0 for 5 cycles → q holds and `tc`=`cout`=0. A mid-run `sclr` while at q=7 → next cycle q=0, `ovf`=0.
